// File: rtl/ram_burst_reader.sv
// ram_burst_reader: reads a burst of consecutive words from a synchronous RAM
// and streams them out over a valid/ready interface via a 2-entry FIFO.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle burst request (sampled only in IDLE)
//   start_addr      first RAM address of the burst
//   len             number of words to read (0..31)
//   busy            burst in progress
//   done            one-cycle pulse after the last word is accepted
//   re, rd          RAM read enable / read address
//   ram_dout        RAM read data, valid the cycle after re
//   m_data, m_valid streamed output word and its valid flag
//   m_ready         downstream accept
module ram_burst_reader #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_BUS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_BUS-1:0] start_addr,
  input  logic [ADDR_BUS:0]   len,
  output logic                busy,
  output logic                done,
  output logic                re,
  output logic [ADDR_BUS-1:0] rd,
  input  logic [WIDTH-1:0]    ram_dout,
  output logic [WIDTH-1:0]    m_data,
  output logic                m_valid,
  input  logic                m_ready
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state, state_d;
  logic [ADDR_BUS:0]   remaining;
  logic                pend;        // a read was issued last cycle; ram_dout holds its data
  logic [CNT_W-1:0]    count, count_d;
  logic [WIDTH-1:0]    tail;        // second FIFO entry; m_data is the head
  logic                done_d;
  logic                load_c;
  logic                push_c;
  logic                pop_c;
  logic [2:0]          occ_c;

  // Next-state, read issue and FIFO bookkeeping.
  // Occupancy credits the word leaving this cycle so that a full-rate stream
  // with m_ready held high sustains one read per cycle; with m_ready low the
  // limit is in-flight + buffered < 2, which can never overflow 2 entries.
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    load_c  = 1'b0;
    re      = 1'b0;
    push_c  = pend;
    pop_c   = m_valid & m_ready;
    occ_c   = 3'(pend) + 3'(count) - 3'(pop_c);
    count_d = count + CNT_W'(push_c) - CNT_W'(pop_c);

    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = READ;
            load_c  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if ((remaining != '0) && (occ_c < 3'd2)) begin
          re = 1'b1;
        end
        if (re && (remaining == (ADDR_BUS+1)'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Final word: nothing in flight and the only buffered word leaves now.
        if (!pend && (count == CNT_W'(1)) && pop_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address/length counters and output FIFO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd        <= '0;
      remaining <= '0;
      pend      <= 1'b0;
      count     <= '0;
      m_data    <= '0;
      tail      <= '0;
      m_valid   <= 1'b0;
    end else begin
      state   <= state_d;
      busy    <= (state_d != IDLE);
      done    <= done_d;
      pend    <= re;
      count   <= count_d;
      m_valid <= (count_d != '0);

      if (load_c) begin
        rd        <= start_addr;
        remaining <= len;
      end else if (re) begin
        rd        <= rd + ADDR_BUS'(1);
        remaining <= remaining - (ADDR_BUS+1)'(1);
      end

      case ({push_c, pop_c})
        2'b10: begin
          if (count == '0) m_data <= ram_dout;
          else             tail   <= ram_dout;
        end
        2'b01: m_data <= tail;
        2'b11: begin
          if (count == CNT_W'(1)) begin
            m_data <= ram_dout;
          end else begin
            m_data <= tail;
            tail   <= ram_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: directed bursts against a RAM model preloaded
// with addr*3; expected addresses and data go into queues checked by a monitor.
module tb_ram_burst_reader;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned ADDR_BUS = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [ADDR_BUS-1:0] start_addr;
  logic [ADDR_BUS:0]   len;
  logic                busy;
  logic                done;
  logic                re;
  logic [ADDR_BUS-1:0] rd;
  logic [WIDTH-1:0]    ram_dout = '0;
  logic [WIDTH-1:0]    m_data;
  logic                m_valid;
  logic                m_ready;

  ram_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BUS(ADDR_BUS)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .re(re), .rd(rd), .ram_dout(ram_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model, 1-cycle read latency
  logic [WIDTH-1:0] mem [DEPTH];
  initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = WIDTH'(i * 3);
  always @(posedge clk) if (re) ram_dout <= mem[rd];

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  int exp_rd_q[$];
  int exp_data_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitor: compares every issued read and every accepted word
  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (re) begin
        if (exp_rd_q.size() == 0) chk("rd_extra_read", int'(rd), -1);
        else chk("rd", int'(rd), exp_rd_q.pop_front());
      end
      if (m_valid && m_ready) begin
        acc_cnt++;
        if (exp_data_q.size() == 0) chk("data_extra_word", int'(m_data), -1);
        else chk("m_data", int'(m_data), exp_data_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic start_burst(input int addr, input int n);
    start      = 1'b1;
    start_addr = ADDR_BUS'(addr);
    len        = (ADDR_BUS+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done_cnt > base) break;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("done_count", done_cnt, base + 1);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic push_burst(input int addr, input int n);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back((addr + i) % DEPTH);
      exp_data_q.push_back((((addr + i) % DEPTH) * 3) % 256);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    int'(busy),    0);
    chk({tag, "_done"},    int'(done),    0);
    chk({tag, "_re"},      int'(re),      0);
    chk({tag, "_rd"},      int'(rd),      0);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_data"},  int'(m_data),  0);
  endtask

  initial begin
    int base;
    int abase;
    int re_n;
    int busy_n;

    rst = 1'b0; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b1;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Basic burst: rd 2..5, data 6,9,12,15, cycle-exact timing
    exp_rd_q.push_back(2);  exp_rd_q.push_back(3);
    exp_rd_q.push_back(4);  exp_rd_q.push_back(5);
    exp_data_q.push_back(6);  exp_data_q.push_back(9);
    exp_data_q.push_back(12); exp_data_q.push_back(15);
    base = done_cnt;
    start_burst(2, 4);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("t1_re",      int'(re),      (i <= 4) ? 1 : 0);
      chk("t1_m_valid", int'(m_valid), (i >= 3 && i <= 6) ? 1 : 0);
      chk("t1_done",    int'(done),    (i == 7) ? 1 : 0);
      chk("t1_busy",    int'(busy),    (i <= 6) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("t1_done_count", done_cnt, base + 1);

    // Address wrap: rd 14,15,0,1 -> data 42,45,0,3
    exp_rd_q.push_back(14); exp_rd_q.push_back(15);
    exp_rd_q.push_back(0);  exp_rd_q.push_back(1);
    exp_data_q.push_back(42); exp_data_q.push_back(45);
    exp_data_q.push_back(0);  exp_data_q.push_back(3);
    base = done_cnt;
    start_burst(14, 4);
    wait_done(base);

    // Backpressure: m_ready low for 6 cycles, len=5 from address 5
    push_burst(5, 5);
    m_ready = 1'b0;
    base = done_cnt;
    re_n = 0;
    start_burst(5, 5);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (re) re_n++;
      if (i >= 3) begin
        chk("stall_m_valid", int'(m_valid), 1);
        chk("stall_m_data",  int'(m_data),  15);
      end
    end
    chk("stall_reads_issued", re_n, 2);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done(base);

    // Zero-length request
    base = done_cnt;
    re_n = 0;
    busy_n = 0;
    start_burst(7, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (re)   re_n++;
      if (busy) busy_n++;
      if (i == 1) chk("len0_done_pulse", int'(done), 1);
    end
    chk("len0_reads", re_n, 0);
    chk("len0_busy_cycles", busy_n, 0);
    @(posedge clk); #1;
    chk("len0_done_count", done_cnt, base + 1);

    // Start pulsed mid-burst is ignored
    exp_rd_q.push_back(3); exp_rd_q.push_back(4); exp_rd_q.push_back(5);
    exp_data_q.push_back(9); exp_data_q.push_back(12); exp_data_q.push_back(15);
    base = done_cnt;
    start_burst(3, 3);
    @(posedge clk); #1;
    start_burst(9, 6);
    wait_done(base);

    // Reset after 2nd accepted word of a len=8 burst from address 4
    exp_rd_q.push_back(4); exp_rd_q.push_back(5);
    exp_rd_q.push_back(6); exp_rd_q.push_back(7);
    exp_data_q.push_back(12); exp_data_q.push_back(15);
    base  = done_cnt;
    abase = acc_cnt;
    start_burst(4, 8);
    for (int i = 0; i < 50; i++) begin
      if (acc_cnt >= abase + 2) break;
      @(posedge clk); #1;
    end
    chk("abort_accepts_before_reset", acc_cnt, abase + 2);
    rst = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) @(posedge clk);
    chk("abort_no_done", done_cnt, base);
    #1;
    rst = 1'b1;
    exp_rd_q.push_back(0);
    exp_data_q.push_back(0);
    start_burst(0, 1);
    wait_done(base);

    chk("rd_queue_left", exp_rd_q.size(), 0);
    chk("data_queue_left", exp_data_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
